qupls_alu_issue_seq: RTL and testbench

QUPLS_ALU_ISSUE_SEQ -- requirements
Module: qupls_alu_issue_seq

---
 rtl/qupls_alu_issue_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_qupls_alu_issue_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qupls_alu_issue_seq.sv
// -----------------------------------------------------------------------------
// qupls_alu_issue_seq
//
// Issue/writeback sequencer for one ALU lane group. It accepts one operation
// at a time, launches it into the ALU, waits for completion (fixed latency for
// simple ops, done strobes for multiply and divide), and holds the result in
// writeback registers until the consumer takes it.
//
// Parameters
//   WID     operand/result width
//   TAGW    destination tag width
//   ALU_LAT cycles for single-cycle ops (1..15)
//   TMO     watchdog limit in cycles (8-bit)
//
// Ports
//   clk, rst                   clock; asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_kind                   0=simple, 1=mul, 2=div, 3=reserved
//   req_prc, req_cptgt, req_tag  lane precision, copy mask, destination tag
//   alu_ld                     one-cycle launch pulse
//   alu_div, alu_prc, alu_cptgt  held from LAUNCH until IDLE
//   alu_o, alu_exc             ALU result and per-lane exception bytes
//   alu_mul_done, alu_div_done, alu_div_dbz  completion strobes
//   wb_valid/wb_ready          writeback handshake
//   wb_res, wb_exc, wb_tag, wb_dbz, wb_tmo   writeback payload
//   flush                      abort; forces IDLE, drops any pending writeback
//
// Optional feature
//   QUPLS_ALU_SEQ_TMO_EN       enables the WAIT watchdog (wb_tmo); without it
//                              WAIT lasts until completion and wb_tmo is 0.
// -----------------------------------------------------------------------------
module qupls_alu_issue_seq #(
    parameter int WID     = 64,
    parameter int TAGW    = 6,
    parameter int ALU_LAT = 1,
    parameter int TMO     = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_kind,
    input  logic [1:0]           req_prc,
    input  logic [WID/8-1:0]     req_cptgt,
    input  logic [TAGW-1:0]      req_tag,
    output logic                 alu_ld,
    output logic                 alu_div,
    output logic [1:0]           alu_prc,
    output logic [WID/8-1:0]     alu_cptgt,
    input  logic [WID-1:0]       alu_o,
    input  logic [WID-1:0]       alu_exc,
    input  logic                 alu_mul_done,
    input  logic                 alu_div_done,
    input  logic                 alu_div_dbz,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [WID-1:0]       wb_res,
    output logic [WID-1:0]       wb_exc,
    output logic [TAGW-1:0]      wb_tag,
    output logic                 wb_dbz,
    output logic                 wb_tmo,
    input  logic                 flush
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_e;

    localparam logic [1:0] K_MUL  = 2'd1;
    localparam logic [1:0] K_DIV  = 2'd2;
    localparam logic [1:0] K_RSVD = 2'd3;
    localparam logic [7:0] LAT_CNT = 8'(ALU_LAT);
    localparam logic [7:0] CNT_MAX = 8'hFF;

    state_e            state_q, state_d;
    logic [1:0]        kind_q, kind_d;
    logic [1:0]        prc_q, prc_d;
    logic [WID/8-1:0]  cptgt_q, cptgt_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              rdy_en_q;
    logic              wb_valid_q, wb_valid_d;
    logic [WID-1:0]    wb_res_q, wb_res_d;
    logic [WID-1:0]    wb_exc_q, wb_exc_d;
    logic [TAGW-1:0]   wb_tag_q, wb_tag_d;
    logic              wb_dbz_q, wb_dbz_d;
`ifdef QUPLS_ALU_SEQ_TMO_EN
    localparam logic [7:0] TMO_CNT = 8'(TMO);
    logic              wb_tmo_q, wb_tmo_d;
`endif

    // The counter is 0 during LAUNCH and equals k in the k-th WAIT cycle, so
    // cnt_q >= 2 marks the second WAIT cycle, where done strobes become valid.
    logic past_first_wait;
    logic op_done;
    assign past_first_wait = (cnt_q >= 8'd2);
    assign op_done = (kind_q == K_MUL) ? (alu_mul_done && past_first_wait) :
                     (kind_q == K_DIV) ? (alu_div_done && past_first_wait) :
                                         (cnt_q >= LAT_CNT);

    // rdy_en_q keeps req_ready low until the first clock after reset release.
    assign req_ready = (state_q == S_IDLE) && rdy_en_q && !flush;
    assign alu_ld    = (state_q == S_LAUNCH);
    assign alu_div   = (state_q != S_IDLE) && (kind_q == K_DIV);
    assign alu_prc   = (state_q != S_IDLE) ? prc_q   : '0;
    assign alu_cptgt = (state_q != S_IDLE) ? cptgt_q : '0;
    assign wb_valid  = wb_valid_q;
    assign wb_res    = wb_res_q;
    assign wb_exc    = wb_exc_q;
    assign wb_tag    = wb_tag_q;
    assign wb_dbz    = wb_dbz_q;
`ifdef QUPLS_ALU_SEQ_TMO_EN
    assign wb_tmo    = wb_tmo_q;
`else
    assign wb_tmo    = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        kind_d     = kind_q;
        prc_d      = prc_q;
        cptgt_d    = cptgt_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        wb_valid_d = wb_valid_q;
        wb_res_d   = wb_res_q;
        wb_exc_d   = wb_exc_q;
        wb_tag_d   = wb_tag_q;
        wb_dbz_d   = wb_dbz_q;
`ifdef QUPLS_ALU_SEQ_TMO_EN
        wb_tmo_d   = wb_tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    kind_d  = req_kind;
                    prc_d   = req_prc;
                    cptgt_d = req_cptgt;
                    tag_d   = req_tag;
                    cnt_d   = '0;
                    if (req_kind == K_RSVD) begin
                        // Reserved kind never touches the ALU; it retires
                        // straight away with an all-ones lane-0 exception.
                        wb_valid_d = 1'b1;
                        wb_res_d   = '0;
                        wb_exc_d   = {{(WID-8){1'b0}}, 8'hFF};
                        wb_tag_d   = req_tag;
                        wb_dbz_d   = 1'b0;
`ifdef QUPLS_ALU_SEQ_TMO_EN
                        wb_tmo_d   = 1'b0;
`endif
                        state_d    = S_HOLD;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = 8'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
                if (op_done) begin
                    wb_valid_d = 1'b1;
                    wb_res_d   = alu_o;
                    wb_exc_d   = alu_exc;
                    wb_tag_d   = tag_q;
                    wb_dbz_d   = (kind_q == K_DIV) && alu_div_dbz;
`ifdef QUPLS_ALU_SEQ_TMO_EN
                    wb_tmo_d   = 1'b0;
`endif
                    state_d    = S_HOLD;
                end
`ifdef QUPLS_ALU_SEQ_TMO_EN
                else if (cnt_q >= TMO_CNT) begin
                    wb_valid_d = 1'b1;
                    wb_res_d   = '0;
                    wb_exc_d   = {{(WID-8){1'b0}}, 8'hFE};
                    wb_tag_d   = tag_q;
                    wb_dbz_d   = 1'b0;
                    wb_tmo_d   = 1'b1;
                    state_d    = S_HOLD;
                end
`endif
            end
            S_HOLD: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush outranks completion and the writeback handshake.
        if (flush) begin
            state_d    = S_IDLE;
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            kind_q     <= '0;
            prc_q      <= '0;
            cptgt_q    <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            rdy_en_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_res_q   <= '0;
            wb_exc_q   <= '0;
            wb_tag_q   <= '0;
            wb_dbz_q   <= 1'b0;
`ifdef QUPLS_ALU_SEQ_TMO_EN
            wb_tmo_q   <= 1'b0;
`endif
        end else begin
            // NOTE: state updates use non-blocking assignment so every
            // register samples the pre-edge values regardless of order.
            state_q    <= state_d;
            kind_q     <= kind_d;
            prc_q      <= prc_d;
            cptgt_q    <= cptgt_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            rdy_en_q   <= 1'b1;
            wb_valid_q <= wb_valid_d;
            wb_res_q   <= wb_res_d;
            wb_exc_q   <= wb_exc_d;
            wb_tag_q   <= wb_tag_d;
            wb_dbz_q   <= wb_dbz_d;
`ifdef QUPLS_ALU_SEQ_TMO_EN
            wb_tmo_q   <= wb_tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_qupls_alu_issue_seq.sv
// -----------------------------------------------------------------------------
// tb_qupls_alu_issue_seq
//
// Directed bench: a table of single-op vectors with hand-computed results,
// followed by hand-written sequences for stale done masking, writeback stall,
// flush, watchdog and mid-operation reset. Inputs are driven and outputs
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_qupls_alu_issue_seq;
    localparam int WID  = 64;
    localparam int TAGW = 6;
    localparam int CW   = WID / 8;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_ready;
    logic [1:0]      req_kind, req_prc;
    logic [CW-1:0]   req_cptgt;
    logic [TAGW-1:0] req_tag;
    logic            alu_ld, alu_div;
    logic [1:0]      alu_prc;
    logic [CW-1:0]   alu_cptgt;
    logic [WID-1:0]  alu_o, alu_exc;
    logic            alu_mul_done, alu_div_done, alu_div_dbz;
    logic            wb_valid, wb_ready;
    logic [WID-1:0]  wb_res, wb_exc;
    logic [TAGW-1:0] wb_tag;
    logic            wb_dbz, wb_tmo, flush;

    qupls_alu_issue_seq #(.WID(WID), .TAGW(TAGW), .ALU_LAT(1), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_prc(req_prc), .req_cptgt(req_cptgt), .req_tag(req_tag),
        .alu_ld(alu_ld), .alu_div(alu_div), .alu_prc(alu_prc), .alu_cptgt(alu_cptgt),
        .alu_o(alu_o), .alu_exc(alu_exc), .alu_mul_done(alu_mul_done),
        .alu_div_done(alu_div_done), .alu_div_dbz(alu_div_dbz),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_res(wb_res), .wb_exc(wb_exc),
        .wb_tag(wb_tag), .wb_dbz(wb_dbz), .wb_tmo(wb_tmo), .flush(flush)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;

    always @(posedge clk) if (wb_valid && wb_ready) hs_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] k, input logic [1:0] p,
                         input logic [CW-1:0] c, input logic [TAGW-1:0] t);
        int w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_before_issue", req_ready, 1);
        req_valid = 1'b1; req_kind = k; req_prc = p; req_cptgt = c; req_tag = t;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  prc;
        logic [7:0]  cptgt;
        logic [5:0]  tag;
        logic [63:0] o;
        logic [63:0] exc;
        logic        dbz;
        int          delay;
        logic [63:0] exp_res;
        logic [63:0] exp_exc;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int hs0;
        int bad;
        logic [63:0] hold_res;

        //          kind prc cptgt  tag    alu_o                   alu_exc  dbz dly exp_res                 exp_exc  dbz lat
        vecs[0] = '{2'd0, 2'd0, 8'hFF, 6'h05, 64'h1234,               64'h0,   1'b0, 0, 64'h1234,               64'h0,   1'b0, 2};
        vecs[1] = '{2'd1, 2'd1, 8'h0F, 6'h2A, 64'hDEAD_BEEF_0000_0001, 64'h0100, 1'b0, 3, 64'hDEAD_BEEF_0000_0001, 64'h0100, 1'b0, 4};
        vecs[2] = '{2'd2, 2'd2, 8'h03, 6'h3F, 64'h7,                  64'h0,   1'b1, 2, 64'h7,                  64'h0,   1'b1, 3};
        vecs[3] = '{2'd2, 2'd0, 8'h80, 6'h01, 64'h55AA,               64'h02,  1'b0, 4, 64'h55AA,               64'h02,  1'b0, 5};
        vecs[4] = '{2'd3, 2'd1, 8'h01, 6'h11, 64'hFFFF,               64'h33,  1'b0, 0, 64'h0,                  64'hFF,  1'b0, 0};
        vecs[5] = '{2'd1, 2'd3, 8'hF0, 6'h22, 64'h0BAD_F00D,          64'h0,   1'b1, 2, 64'h0BAD_F00D,          64'h0,   1'b0, 3};

        rst = 1'b0; req_valid = 1'b0; req_kind = '0; req_prc = '0; req_cptgt = '0; req_tag = '0;
        alu_o = '0; alu_exc = '0; alu_mul_done = 1'b0; alu_div_done = 1'b0; alu_div_dbz = 1'b0;
        wb_ready = 1'b1; flush = 1'b0;

        // Reset state
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_alu_ld", alu_ld, 0);
        check("rst_wb_tmo", wb_tmo, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1 check("ready_low_before_clock", req_ready, 0);
        @(negedge clk);
        check("ready_after_release", req_ready, 1);

        // Table-driven single operations
        foreach (vecs[i]) begin
            alu_o = vecs[i].o; alu_exc = vecs[i].exc; alu_div_dbz = vecs[i].dbz;
            hs0 = hs_cnt;
            issue(vecs[i].kind, vecs[i].prc, vecs[i].cptgt, vecs[i].tag);
            check($sformatf("v%0d_alu_ld", i), alu_ld, vecs[i].kind != 2'd3);
            if (vecs[i].kind != 2'd3) begin
                check($sformatf("v%0d_alu_div", i), alu_div, vecs[i].kind == 2'd2);
                check($sformatf("v%0d_alu_prc", i), alu_prc, vecs[i].prc);
                check($sformatf("v%0d_alu_cptgt", i), alu_cptgt, vecs[i].cptgt);
            end
            lat = 0;
            while (!wb_valid && lat < 50) begin
                @(negedge clk);
                lat++;
                if (lat == vecs[i].delay) begin
                    if (vecs[i].kind == 2'd1) alu_mul_done = 1'b1;
                    if (vecs[i].kind == 2'd2) alu_div_done = 1'b1;
                end
            end
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_wb_valid", i), wb_valid, 1);
            check($sformatf("v%0d_alu_ld_once", i), alu_ld, 0);
            check($sformatf("v%0d_wb_res", i), wb_res, vecs[i].exp_res);
            check($sformatf("v%0d_wb_exc", i), wb_exc, vecs[i].exp_exc);
            check($sformatf("v%0d_wb_tag", i), wb_tag, vecs[i].tag);
            check($sformatf("v%0d_wb_dbz", i), wb_dbz, vecs[i].exp_dbz);
            check($sformatf("v%0d_wb_tmo", i), wb_tmo, 0);
            alu_mul_done = 1'b0; alu_div_done = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_wb_valid_one_cycle", i), wb_valid, 0);
            check($sformatf("v%0d_ready_back", i), req_ready, 1);
            check($sformatf("v%0d_handshakes", i), hs_cnt - hs0, 1);
        end

        // Stale mul done from the prior op held through the first WAIT cycle
        alu_mul_done = 1'b1; alu_o = 64'hBAD; alu_exc = '0;
        issue(2'd1, 2'd0, 8'h01, 6'h0C);          // LAUNCH
        @(negedge clk);                            // WAIT 1: stale done still 1
        @(negedge clk);                            // WAIT 2
        check("stale_done_ignored", wb_valid, 0);
        alu_mul_done = 1'b0; alu_o = 64'hC0FFEE;
        @(negedge clk); @(negedge clk); @(negedge clk);  // WAIT 5
        check("stale_still_waiting", wb_valid, 0);
        alu_mul_done = 1'b1;
        @(negedge clk);
        check("stale_real_done_valid", wb_valid, 1);
        check("stale_real_done_res", wb_res, 64'hC0FFEE);
        check("stale_real_done_tag", wb_tag, 6'h0C);
        alu_mul_done = 1'b0;
        @(negedge clk);

        // Divide by zero with the consumer stalled for three HOLD cycles
        wb_ready = 1'b0; alu_o = 64'h99; alu_exc = 64'h04; alu_div_dbz = 1'b1;
        hs0 = hs_cnt;
        issue(2'd2, 2'd3, 8'h0C, 6'h15);
        check("div_alu_div_launch", alu_div, 1);
        @(negedge clk);
        alu_div_done = 1'b1;
        @(negedge clk); @(negedge clk);
        check("div_wb_valid", wb_valid, 1);
        check("div_wb_dbz", wb_dbz, 1);
        hold_res = wb_res;
        check("div_wb_res", hold_res, 64'h99);
        alu_div_done = 1'b0; alu_div_dbz = 1'b0; alu_o = 64'h1111; alu_exc = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("div_stall%0d_valid", k), wb_valid, 1);
            check($sformatf("div_stall%0d_res", k), wb_res, 64'h99);
            check($sformatf("div_stall%0d_exc", k), wb_exc, 64'h04);
            check($sformatf("div_stall%0d_dbz", k), wb_dbz, 1);
            check($sformatf("div_stall%0d_alu_div", k), alu_div, 1);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        check("div_released", wb_valid, 0);
        check("div_single_handshake", hs_cnt - hs0, 1);
        check("div_alu_div_idle", alu_div, 0);

        // Flush in WAIT on the same cycle as div done
        hs0 = hs_cnt;
        issue(2'd2, 2'd0, 8'h01, 6'h07);
        @(negedge clk);
        alu_div_done = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_no_wb_valid", wb_valid, 0);
        check("flush_ready_low", req_ready, 0);
        flush = 1'b0; alu_div_done = 1'b0;
        #1 check("flush_idle_ready", req_ready, 1);
        @(negedge clk); @(negedge clk);
        check("flush_no_late_wb", wb_valid, 0);
        check("flush_no_handshake", hs_cnt - hs0, 0);

        // Flush while holding a stalled result
        wb_ready = 1'b0; alu_o = 64'h42;
        issue(2'd0, 2'd0, 8'h01, 6'h08);
        @(negedge clk); @(negedge clk);
        check("hold_flush_pre", wb_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; wb_ready = 1'b1;
        check("hold_flush_cleared", wb_valid, 0);
        #1 check("hold_flush_idle", req_ready, 1);
        @(negedge clk);

        // Watchdog
        hs0 = hs_cnt;
        issue(2'd1, 2'd0, 8'h01, 6'h19);
`ifdef QUPLS_ALU_SEQ_TMO_EN
        lat = 0;
        while (!wb_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("tmo_latency", lat, TMO + 1);
        check("tmo_flag", wb_tmo, 1);
        check("tmo_exc", wb_exc[7:0], 8'hFE);
        check("tmo_res", wb_res, 0);
        check("tmo_tag", wb_tag, 6'h19);
        @(negedge clk);
        check("tmo_released", req_ready, 1);
`else
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (wb_valid || req_ready || wb_tmo) bad++;
        end
        check("no_tmo_still_waiting", bad, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 check("no_tmo_flush_recover", req_ready, 1);
`endif

        // Reset pulsed during WAIT
        alu_o = 64'h77;
        issue(2'd1, 2'd2, 8'hAA, 6'h2C);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_req_ready", req_ready, 0);
        check("rst_mid_wb_valid", wb_valid, 0);
        check("rst_mid_alu_prc", alu_prc, 0);
        check("rst_mid_alu_cptgt", alu_cptgt, 0);
        check("rst_mid_wb_res", wb_res, 0);
        check("rst_mid_wb_tag", wb_tag, 0);
        @(negedge clk);
        alu_mul_done = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready_after", req_ready, 1);
        check("rst_mid_no_wb", wb_valid, 0);
        alu_mul_done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
